envelope_bank: RTL and testbench

Time-multiplexed, multi-channel envelope follower for the vocoder analysis path. It sits after the band-split filter bank and accepts one band sample per cycle, tagged with its channel index. For each sample it rectifies the input and updates that channel's envelope with an asymmetric one-pole smoother, using separate attack and release time constants. It produces one envelope value per accepted sample, in order, with fixed latency, for the carrier-modulation stage.

---
 rtl/envelope_bank_if.sv | 25 ++
 rtl/envelope_bank.sv | 128 ++++++++++++
 tb/tb_envelope_bank.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/envelope_bank_if.sv
// Sample/envelope bus for envelope_bank: band samples in, envelopes out.
interface envelope_bank_if #(
    parameter int WIDTH = 24,
    parameter int CH_W  = 4
);
    logic                    valid_in;
    logic [CH_W-1:0]         channel_in;
    logic signed [WIDTH-1:0] sample_in;
    logic                    half_wave_in;
    logic                    clear_in;
    logic                    valid_out;
    logic [CH_W-1:0]         channel_out;
    logic signed [WIDTH-1:0] envelope_out;
    logic                    busy_out;

    modport master (
        output valid_in, channel_in, sample_in, half_wave_in, clear_in,
        input  valid_out, channel_out, envelope_out, busy_out
    );

    modport slave (
        input  valid_in, channel_in, sample_in, half_wave_in, clear_in,
        output valid_out, channel_out, envelope_out, busy_out
    );
endinterface

// File: rtl/envelope_bank.sv
// Time-multiplexed multi-channel envelope follower with asymmetric
// attack/release one-pole smoothing and a one-channel-per-cycle clear sweep.
module envelope_bank #(
    parameter int WIDTH         = 24,
    parameter int CHANNELS      = 16,
    parameter int ATTACK_SHIFT  = 4,
    parameter int RELEASE_SHIFT = 10
) (
    input logic            clk_in,
    input logic            rst_in,
    envelope_bank_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FRAC  = RELEASE_SHIFT;
    localparam int MAG_W = WIDTH - 1;
    localparam int SW    = WIDTH - 1 + FRAC;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [CH_W-1:0]   sweep_idx;
    logic [SW-1:0]     env_state [CHANNELS];

    logic [WIDTH-1:0]  neg;
    logic [MAG_W-1:0]  mag;
    logic              accept;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [MAG_W-1:0]  s1_mag;

    logic [SW-1:0]     cur;
    logic [SW-1:0]     target;
    logic signed [SW:0] diff;
    logic signed [SW:0] step;
    logic signed [SW:0] sum;
    logic [SW-1:0]     s_new;

    logic              s2_valid;
    logic [CH_W-1:0]   s2_ch;
    logic [MAG_W-1:0]  s2_env;

    // Rectify the incoming sample and decide whether it is accepted.
    always_comb begin
        neg = '0 - bus.sample_in;
        mag = '0;
        if (!bus.sample_in[WIDTH-1]) begin
            mag = bus.sample_in[MAG_W-1:0];
        end else if (!bus.half_wave_in) begin
            // Only the most negative input overflows the negation.
            mag = neg[WIDTH-1] ? '1 : neg[MAG_W-1:0];
        end
        accept = bus.valid_in && !bus.clear_in && (state == IDLE) &&
                 (int'(bus.channel_in) < CHANNELS);
    end

    // Smoother update; state is read and written in the same stage, so
    // back-to-back samples on one channel see each other without forwarding.
    always_comb begin
        cur    = env_state[s1_ch];
        target = {s1_mag, {FRAC{1'b0}}};
        diff   = $signed({1'b0, target}) - $signed({1'b0, cur});
        step   = (diff > 0) ? (diff >>> ATTACK_SHIFT) : (diff >>> RELEASE_SHIFT);
        sum    = $signed({1'b0, cur}) + step;
        s_new  = sum[SW] ? '0 : sum[SW-1:0];
    end

    // Capture stage: rectified magnitude and channel of each accepted sample.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= accept;
            s1_ch    <= bus.channel_in;
            s1_mag   <= mag;
        end
    end

    // Clear FSM and per-channel state; write-back is suppressed while clearing.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            sweep_idx <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                env_state[i] <= '0;
            end
        end else begin
            if (s1_valid && !bus.clear_in && (state == IDLE)) begin
                env_state[s1_ch] <= s_new;
            end
            if (bus.clear_in) begin
                state     <= CLEAR;
                sweep_idx <= '0;
            end else if (state == CLEAR) begin
                env_state[sweep_idx] <= '0;
                if (int'(sweep_idx) == CHANNELS - 1) begin
                    state <= IDLE;
                end else begin
                    sweep_idx <= sweep_idx + 1'b1;
                end
            end
        end
    end

    // Result stage followed by registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2_valid         <= 1'b0;
            s2_ch            <= '0;
            s2_env           <= '0;
            bus.valid_out    <= 1'b0;
            bus.channel_out  <= '0;
            bus.envelope_out <= '0;
        end else begin
            s2_valid         <= s1_valid;
            s2_ch            <= s1_ch;
            s2_env           <= s_new[SW-1:FRAC];
            bus.valid_out    <= s2_valid;
            bus.channel_out  <= s2_ch;
            bus.envelope_out <= {1'b0, s2_env};
        end
    end

    assign bus.busy_out = (state == CLEAR);

endmodule

// File: tb/tb_envelope_bank.sv
// Scoreboard bench for envelope_bank with a behavioural envelope model.
module tb_envelope_bank;
    localparam int NCH   = 3;
    localparam int ASH   = 2;
    localparam int RSH   = 4;
    localparam int MAXV  = 8388607;

    typedef struct {
        int ch;
        int env;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int busy_left = 0;
    longint model_s [NCH];
    exp_t exp_q [$];

    envelope_bank_if #(.WIDTH(24), .CH_W(2)) bus ();

    envelope_bank #(
        .WIDTH(24),
        .CHANNELS(NCH),
        .ATTACK_SHIFT(ASH),
        .RELEASE_SHIFT(RSH)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Envelope scaled by 2^RSH, moved a fraction of the way toward the target.
    function automatic int model_update(input int ch, input int smp, input bit hw);
        longint m, d, tgt;
        if (smp >= 0) m = smp;
        else m = hw ? 0 : -longint'(smp);
        if (m > MAXV) m = MAXV;
        tgt = m * (longint'(1) << RSH);
        d = tgt - model_s[ch];
        if (d > 0) model_s[ch] = model_s[ch] + floordiv(d, longint'(1) << ASH);
        else model_s[ch] = model_s[ch] + floordiv(d, longint'(1) << RSH);
        return int'(model_s[ch] / (longint'(1) << RSH));
    endfunction

    task automatic drive(input bit v, input int ch, input int smp, input bit hw, input bit clr);
        logic [31:0] s32;
        exp_t e;
        @(posedge clk);
        #1;
        s32 = smp;
        bus.valid_in     = v;
        bus.channel_in   = ch[1:0];
        bus.sample_in    = s32[23:0];
        bus.half_wave_in = hw;
        bus.clear_in     = clr;
        checks++;
        if (bus.busy_out !== (busy_left > 0)) begin
            errors++;
            $display("FAIL busy_out: got %0b expected %0b at %0t", bus.busy_out, busy_left > 0, $time);
        end
        if (v && !clr && busy_left == 0 && ch < NCH) begin
            e.ch  = ch;
            e.env = model_update(ch, smp, hw);
            exp_q.push_back(e);
        end
        if (clr) begin
            busy_left = NCH;
            for (int i = 0; i < NCH; i++) model_s[i] = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name, input int got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL %s: got %0d expected 0", name, got);
        end
    endtask

    // Monitor: every emitted envelope must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: ch %0d env %0d with nothing expected",
                         bus.channel_out, bus.envelope_out);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.channel_out) != e.ch || int'(bus.envelope_out) != e.env) begin
                    errors++;
                    $display("FAIL envelope: got ch %0d env %0d expected ch %0d env %0d",
                             bus.channel_out, bus.envelope_out, e.ch, e.env);
                end
            end
        end
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.channel_in = '0;
        bus.sample_in = '0;
        bus.half_wave_in = 1'b0;
        bus.clear_in = 1'b0;
        for (int i = 0; i < NCH; i++) model_s[i] = 0;
        #2;
        check_zero("reset_valid", int'(bus.valid_out));
        check_zero("reset_busy", int'(bus.busy_out));
        #10 rst_n = 1'b1;

        // Attack back-to-back on one channel.
        drive(1'b1, 0, 1048576, 1'b0, 1'b0);
        drive(1'b1, 0, 1048576, 1'b0, 1'b0);
        idle(4);
        // Release.
        drive(1'b1, 1, 1048576, 1'b0, 1'b0);
        drive(1'b1, 1, 0, 1'b0, 1'b0);
        idle(4);
        // Rectify modes around a clear.
        drive(1'b1, 2, -8388608, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(5);
        drive(1'b1, 2, -8388608, 1'b1, 1'b0);
        idle(3);
        // Independence and out-of-range channel.
        drive(1'b1, 0, 1048576, 1'b0, 1'b0);
        drive(1'b1, 1, -1048576, 1'b0, 1'b0);
        drive(1'b1, 3, 1048576, 1'b0, 1'b0);
        // Clear together with a sample, samples while busy, then resume.
        drive(1'b1, 0, 1048576, 1'b0, 1'b1);
        drive(1'b1, 0, 5000000, 1'b0, 1'b0);
        drive(1'b1, 1, 5000000, 1'b0, 1'b0);
        drive(1'b1, 2, 5000000, 1'b0, 1'b0);
        drive(1'b1, 0, 1048576, 1'b0, 1'b0);
        idle(4);

        // Asynchronous reset with samples in flight.
        drive(1'b1, 0, 3000000, 1'b0, 1'b0);
        drive(1'b1, 1, 3000000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_valid_out", int'(bus.valid_out));
        check_zero("rst_channel_out", int'(bus.channel_out));
        check_zero("rst_envelope_out", int'(bus.envelope_out));
        check_zero("rst_busy_out", int'(bus.busy_out));
        exp_q.delete();
        for (int i = 0; i < NCH; i++) model_s[i] = 0;
        busy_left = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int smp;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: smp = -8388608;
                1: smp = 8388607;
                2: smp = 0;
                3: smp = int'($urandom_range(0, 2000)) - 1000;
                default: smp = int'($urandom_range(0, 16777215)) - 8388608;
            endcase
            drive(($urandom % 4) != 0, int'($urandom_range(0, 3)), smp,
                  $urandom_range(0, 1) == 1, ($urandom % 40) == 0);
        end
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
